// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, reset PC, nop encoding and fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jalr > branch/jal > sequential) with misalignment detect.
module next_pc_sel #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            next_misaligned
);

    // jalr clears bit 0, so only bit 1 can flag a misaligned target
    always_comb begin
        next_pc = PCPlus4;
        if (jalr) begin
            next_pc = ALUResult & ~XLEN'(1);
        end else if (Branch || Jump) begin
            next_pc = PCTarget;
        end
        next_misaligned = next_pc[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, fetches one instruction at a time, retires on instr_ready.
module fetch_unit #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        Instr,
    output logic [XLEN-1:0]    PC,
    output logic [XLEN-1:0]    PCPlus4,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               jalr,
    input  logic [XLEN-1:0]    PCTarget,
    input  logic [XLEN-1:0]    ALUResult,
    output logic               misaligned,
    output logic [31:0]        instret
);
    import riscv_pkg::*;

    localparam logic [1:0] S_REQ  = FETCH_REQ;
    localparam logic [1:0] S_WAIT = FETCH_WAIT;
    localparam logic [1:0] S_HOLD = FETCH_HOLD;
    localparam logic [1:0] S_HALT = FETCH_HALT;

    logic [1:0]      state;
    logic [1:0]      stateNext;
    logic            latchInstr;
    logic            retire;
    logic [XLEN-1:0] nextPc;
    logic            nextMisaligned;

    assign PCPlus4             = PC + XLEN'(4);
    assign imem.imem_req_valid = (state == S_REQ);
    assign imem.imem_addr      = PC;
    assign instr_valid         = (state == S_HOLD);
    assign misaligned          = (state == S_HALT);

    next_pc_sel #(
        .XLEN(XLEN)
    ) u_next_pc_sel (
        .PCPlus4        (PCPlus4),
        .PCTarget       (PCTarget),
        .ALUResult      (ALUResult),
        .Branch         (Branch),
        .Jump           (Jump),
        .jalr           (jalr),
        .next_pc        (nextPc),
        .next_misaligned(nextMisaligned)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake decode; responses outside WAIT are dropped
    always_comb begin
        stateNext  = state;
        latchInstr = 1'b0;
        retire     = 1'b0;
        case (state)
            S_REQ: begin
                if (imem.imem_req_ready) begin
                    stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    latchInstr = 1'b1;
                    stateNext  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    retire    = 1'b1;
                    stateNext = nextMisaligned ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                stateNext = S_HALT;
            end
            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    // Instruction register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Instr <= NOP_INSTR;
        end else if (latchInstr) begin
            Instr <= imem.imem_rsp_data;
        end
    end

    // PC and retired-instruction counter advance together on retire
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PC      <= RESET_PC;
            instret <= 32'd0;
        end else if (retire) begin
            PC      <= nextPc;
            instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, control flow, stalls, halt and reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        instrReady;
    logic        branch;
    logic        jump;
    logic        jalrIn;
    logic [31:0] pcTarget;
    logic [31:0] aluResult;
    logic        misaligned;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] expRet = 32'd0;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem       (bus),
        .Instr      (instr),
        .PC         (pc),
        .PCPlus4    (pcPlus4),
        .instr_valid(instrValid),
        .instr_ready(instrReady),
        .Branch     (branch),
        .Jump       (jump),
        .jalr       (jalrIn),
        .PCTarget   (pcTarget),
        .ALUResult  (aluResult),
        .misaligned (misaligned),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    // One full fetch/retire of the instruction at address a; called at a negedge in REQ
    task automatic fetch(input logic [31:0] a, input logic br, input logic jmp, input logic jr,
                         input logic [31:0] tgt, input logic [31:0] alu,
                         input int reqStall, input int rdyStall);
        chk("req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("imem_addr", bus.imem_addr, a);
        chk("instr_valid_req", 32'(instrValid), 32'd0);
        for (int i = 0; i < reqStall; i++) begin
            bus.imem_req_ready = 1'b0;
            cyc();
            chk("addr_stall", bus.imem_addr, a);
            chk("req_valid_stall", 32'(bus.imem_req_valid), 32'd1);
        end
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        chk("req_valid_wait", 32'(bus.imem_req_valid), 32'd0);
        chk("instr_valid_wait", 32'(instrValid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = instrFor(a);
        cyc();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        chk("instr_valid_hold", 32'(instrValid), 32'd1);
        chk("instr", instr, instrFor(a));
        chk("pc", pc, a);
        chk("pc_plus4", pcPlus4, a + 32'd4);
        chk("instret_hold", instret, expRet);
        for (int i = 0; i < rdyStall; i++) begin
            if (i == 2) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hBAD0_BAD0;
            end
            cyc();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'd0;
            chk("instr_stall", instr, instrFor(a));
            chk("pc_stall", pc, a);
            chk("instr_valid_stall", 32'(instrValid), 32'd1);
            chk("instret_stall", instret, expRet);
        end
        instrReady = 1'b1;
        branch     = br;
        jump       = jmp;
        jalrIn     = jr;
        pcTarget   = tgt;
        aluResult  = alu;
        cyc();
        instrReady = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalrIn     = 1'b0;
        pcTarget   = 32'hFFFF_FFF0;
        aluResult  = 32'hFFFF_FFF0;
        expRet     = expRet + 32'd1;
        chk("instret_retire", instret, expRet);
        chk("instr_valid_after", 32'(instrValid), 32'd0);
    endtask

    initial begin
        reset_n            = 1'b0;
        instrReady         = 1'b0;
        branch             = 1'b0;
        jump               = 1'b0;
        jalrIn             = 1'b0;
        pcTarget           = 32'd0;
        aluResult          = 32'd0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;

        cyc();
        cyc();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_valid", 32'(instrValid), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_instret", instret, 32'd0);
        reset_n = 1'b1;
        cyc();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);

        // Sequential fetch
        fetch(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        fetch(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        fetch(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        chk("instret_three", instret, 32'd3);
        fetch(32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);

        // Taken branch 0x10 -> 0x40, not-taken at 0x40, jal back to 0x10, not-taken -> 0x14
        fetch(32'h10, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0, 0);
        fetch(32'h40, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 0, 0);
        fetch(32'h44, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 0);
        fetch(32'h10, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, 0);

        // jalr with Jump also set: jalr wins, bit 0 cleared
        fetch(32'h14, 1'b0, 1'b1, 1'b1, 32'h200, 32'h101, 0, 0);
        chk("jalr_pc", pc, 32'h100);
        chk("jalr_misaligned", 32'(misaligned), 32'd0);

        // Back-pressure on both sides plus a spurious response in HOLD
        fetch(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5, 5);

        // jal to a misaligned target halts the fetch stage
        fetch(32'h104, 1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 0, 0);
        chk("halt_misaligned", 32'(misaligned), 32'd1);
        chk("halt_pc", pc, 32'h22);
        chk("halt_instret", instret, 32'd11);
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
        end
        bus.imem_req_ready = 1'b0;

        // Asynchronous reset out of HALT
        reset_n = 1'b0;
        #1;
        chk("halt_rst_pc", pc, 32'h0);
        chk("halt_rst_misaligned", 32'(misaligned), 32'd0);
        chk("halt_rst_instret", instret, 32'd0);
        expRet = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // Reset while WAITing; response arrives with the reset release
        chk("w_req_valid", 32'(bus.imem_req_valid), 32'd1);
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        chk("w_in_wait", 32'(bus.imem_req_valid), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("w_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        @(negedge clk);
        reset_n            = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        chk("w_instr", instr, 32'h0000_0013);
        chk("w_instr_valid", 32'(instrValid), 32'd0);
        fetch(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
        chk("w_next_pc", pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
